// File: rtl/dmux8way16_buffered.sv
// ---------------------------------------------------------------------------
// dmux8way16_buffered
//
// Buffered 1-to-8 demultiplexer. It steers one WIDTH-bit input word to one of
// eight output channels, chosen by sel. Each channel has a one-deep holding
// slot with its own valid/ready handshake. A stalled consumer therefore blocks
// only its own channel.
//
// Ports:
//   clock      in   1        system clock; all state changes on rising edge
//   reset      in   1        synchronous active-high reset
//   in         in   WIDTH    word to route
//   sel        in   3        destination channel 0..7 (used when in_valid=1)
//   in_valid   in   1        in/sel valid this cycle
//   in_ready   out  1        block accepts in this cycle (combinational)
//   out        out  8*WIDTH  channel i data on [WIDTH*i +: WIDTH]; 0 when empty
//   out_valid  out  8        channel i slot holds a word (registered)
//   out_ready  in   8        consumer i takes its word this cycle
//   delivered  out  16       only with DMUX_DELIVERED_COUNT_EN: running count
//                            of completed output handshakes, modulo 2^16
//
// Optional feature macro: DMUX_DELIVERED_COUNT_EN
// ---------------------------------------------------------------------------
module dmux8way16_buffered #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready
`ifdef DMUX_DELIVERED_COUNT_EN
    ,
    output logic [15:0]          delivered
`endif
);

    logic [7:0]       r_full;
    logic [WIDTH-1:0] r_data [8];

    logic             w_accept;
    logic [7:0]       w_load;
    logic [7:0]       w_drain;

    // A slot can take a word when it is empty or is being emptied this cycle.
    assign in_ready = ~r_full[sel] | out_ready[sel];
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_full & out_ready;

    // Decode the accepted word into a one-hot load strobe for its channel.
    always_comb begin
        w_load = 8'h00;
        if (w_accept) begin
            w_load[sel] = 1'b1;
        end else begin
            w_load = 8'h00;
        end
    end

    // Per-channel slot update. Reload takes priority over drain, so a channel
    // that drains and reloads on the same edge stays full with no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_full <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_load[i]) begin
                    r_full[i] <= 1'b1;
                    r_data[i] <= in;
                end else if (w_drain[i]) begin
                    // Clear data on drain so an empty slot reads as zero.
                    r_full[i] <= 1'b0;
                    r_data[i] <= '0;
                end else begin
                    r_full[i] <= r_full[i];
                    r_data[i] <= r_data[i];
                end
            end
        end
    end

    assign out_valid = r_full;

    // Flatten the channel slots onto the wide output bus.
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_out
            assign out[WIDTH*g +: WIDTH] = r_data[g];
        end
    endgenerate

`ifdef DMUX_DELIVERED_COUNT_EN
    logic [15:0] r_delivered;

    // Number of set bits in an 8-bit handshake vector.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Running total of completed output handshakes over all channels.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_delivered <= 16'h0000;
        end else begin
            r_delivered <= r_delivered + {12'h000, popcount8(w_drain)};
        end
    end

    assign delivered = r_delivered;
`endif

endmodule
